id_ex_stage: RTL

ID/EX pipeline stage of the DLX integer pipeline; it sits directly upstream of the ALU. It registers decoded instructions from ID and resolves operand hazards by forwarding from EX/MEM and MEM/WB. It detects load-use hazards and inserts one bubble, and it presents the ALU A/B operands and op code plus the memory/writeback controls carried to EX/MEM.

---
 rtl/id_ex_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the DLX integer pipeline: captures decoded ID fields,
// forwards EX/MEM and MEM/WB results into the ALU operands and inserts load-use bubbles.
module id_ex_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [REGBITS-1:0] id_rs1,
    input  logic [REGBITS-1:0] id_rs2,
    input  logic [REGBITS-1:0] id_rd,
    input  logic               id_rs2_used,
    input  logic [WIDTH-1:0]   id_rs1_data,
    input  logic [WIDTH-1:0]   id_rs2_data,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic               id_use_imm,
    input  logic [4:0]         id_alu_op,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [REGBITS-1:0] exmem_rd,
    input  logic               exmem_reg_write,
    input  logic               exmem_mem_read,
    input  logic [WIDTH-1:0]   exmem_result,
    input  logic [REGBITS-1:0] memwb_rd,
    input  logic               memwb_reg_write,
    input  logic [WIDTH-1:0]   memwb_result,
    input  logic               flush,
    input  logic               mem_stall,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [REGBITS-1:0] ex_rd,
    output logic [4:0]         ex_alu_op,
    output logic [WIDTH-1:0]   ex_A,
    output logic [WIDTH-1:0]   ex_B,
    output logic [WIDTH-1:0]   ex_store_data,
    output logic               id_hold,
    output logic [15:0]        bubble_count
);

    localparam int unsigned OPBITS  = 5;
    localparam int unsigned CNTBITS = 16;
    localparam logic [OPBITS-1:0] ALU_ADD = OPBITS'(2);

    logic               valid_q, valid_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               use_imm_q, use_imm_d;
    logic [OPBITS-1:0]  alu_op_q, alu_op_d;
    logic [REGBITS-1:0] rs1_q, rs1_d;
    logic [REGBITS-1:0] rs2_q, rs2_d;
    logic [REGBITS-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]   rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0]   rs2_data_q, rs2_data_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [CNTBITS-1:0] bubble_count_q, bubble_count_d;

    logic load_use_hazard;
    logic insert_bubble;
    logic exmem_fwd1, exmem_fwd2;
    logic memwb_fwd1, memwb_fwd2;
    logic wb_id1, wb_id2;
    logic [WIDTH-1:0] fwd1, fwd2;

    // Load in EX whose destination is read by the instruction now in ID.
    assign load_use_hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                             ((id_rs1 == rd_q) || (id_rs2_used && (id_rs2 == rd_q)));
    assign insert_bubble   = load_use_hazard && !flush && !mem_stall;
    assign id_hold         = mem_stall || (load_use_hazard && !flush);

    // A loaded EX/MEM value is not available yet, so only ALU results forward from EX/MEM.
    assign exmem_fwd1 = exmem_reg_write && !exmem_mem_read && (exmem_rd != '0) && (exmem_rd == rs1_q);
    assign exmem_fwd2 = exmem_reg_write && !exmem_mem_read && (exmem_rd != '0) && (exmem_rd == rs2_q);
    assign memwb_fwd1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q);
    assign memwb_fwd2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q);
    assign wb_id1     = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1);
    assign wb_id2     = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2);

    always_comb begin : operand_forward
        fwd1 = rs1_data_q;
        fwd2 = rs2_data_q;
        if (exmem_fwd1) begin
            fwd1 = exmem_result;
        end else if (memwb_fwd1) begin
            fwd1 = memwb_result;
        end
        if (exmem_fwd2) begin
            fwd2 = exmem_result;
        end else if (memwb_fwd2) begin
            fwd2 = memwb_result;
        end
    end

    always_comb begin : next_state
        valid_d        = valid_q;
        reg_write_d    = reg_write_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        use_imm_d      = use_imm_q;
        alu_op_d       = alu_op_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        imm_d          = imm_q;
        bubble_count_d = bubble_count_q;

        if (flush || insert_bubble) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            use_imm_d   = 1'b0;
            alu_op_d    = ALU_ADD;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
        end else if (mem_stall) begin
            // Keep held operands current with whatever retires while frozen.
            rs1_data_d = memwb_fwd1 ? memwb_result : rs1_data_q;
            rs2_data_d = memwb_fwd2 ? memwb_result : rs2_data_q;
        end else begin
            valid_d     = id_valid;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            use_imm_d   = id_use_imm;
            alu_op_d    = id_alu_op;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rs1_data_d  = wb_id1 ? memwb_result : id_rs1_data;
            rs2_data_d  = wb_id2 ? memwb_result : id_rs2_data;
            imm_d       = id_imm;
        end

        if (insert_bubble && (bubble_count_q != '1)) begin
            bubble_count_d = bubble_count_q + CNTBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            use_imm_q      <= 1'b0;
            alu_op_q       <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            bubble_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            use_imm_q      <= use_imm_d;
            alu_op_q       <= alu_op_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_rd         = rd_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_A          = fwd1;
    assign ex_B          = use_imm_q ? imm_q : fwd2;
    assign ex_store_data = fwd2;
    assign bubble_count  = bubble_count_q;

endmodule
